imm_gen_pipe: RTL and testbench

- Parametrised, registered immediate-generation stage for the decode path.
- Takes a raw instruction with a valid/ready handshake and extracts the sign- or zero-extended immediate at XLEN width.
- Also reports the instruction format and flags illegal encodings.
- Sits between fetch/IF-ID and the ALU/branch operand muxes; carries a tag (PC or ROB index) alongside each result.

---
 rtl/imm_gen_pipe.sv | 154 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage: decodes a raw RISC-V instruction into its
// extended immediate, format code and illegal flag, with a sideband tag carried alongside.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 32,
  parameter int ENABLE_RV64 = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  if (!(XLEN == 32 || XLEN == 64) || (ENABLE_RV64 != 0 && XLEN != 64)) begin : g_bad_cfg
    $fatal(1, "imm_gen_pipe: unsupported XLEN/ENABLE_RV64 combination");
  end

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;

  // Native shift-amount width: bit 25 is part of shamt only on a 64-bit datapath.
  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt_nat, shamt_w;
  logic [XLEN-1:0] imm_d;
  logic [2:0]      fmt_d;
  logic            illegal_d;
  logic            accept;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i     = XLEN'($signed(in_inst[31:20]));
  assign imm_s     = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b     = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_j     = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  assign imm_u     = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign shamt_nat = XLEN'(in_inst[20 +: SHW]);
  assign shamt_w   = XLEN'(in_inst[24:20]);

  always_comb begin
    imm_d     = '0;
    fmt_d     = FMT_NONE;
    illegal_d = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        if (!is_shift) begin
          fmt_d = FMT_I;
          imm_d = imm_i;
        end else if (XLEN == 32 && in_inst[25]) begin
          illegal_d = 1'b1;
        end else begin
          fmt_d = FMT_SHAMT;
          imm_d = shamt_nat;
        end
      end
      OPC_OP_IMM_32: begin
        if (ENABLE_RV64 == 0) begin
          illegal_d = 1'b1;
        end else if (!is_shift) begin
          fmt_d = FMT_I;
          imm_d = imm_i;
        end else if (in_inst[25]) begin
          illegal_d = 1'b1;
        end else begin
          fmt_d = FMT_SHAMT;
          imm_d = shamt_w;
        end
      end
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        fmt_d = FMT_I;
        imm_d = imm_i;
      end
      OPC_STORE: begin
        fmt_d = FMT_S;
        imm_d = imm_s;
      end
      OPC_BRANCH: begin
        fmt_d = FMT_B;
        imm_d = imm_b;
      end
      OPC_JAL: begin
        fmt_d = FMT_J;
        imm_d = imm_j;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_d = FMT_U;
        imm_d = imm_u;
      end
      OPC_OP: begin
        fmt_d = FMT_NONE;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Handshake: a transfer happens on a rising edge where valid && ready. in_ready is
  // !out_valid || out_ready and never looks at in_valid; flush wins over any accept.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_fmt     <= FMT_NONE;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (in_ready) begin
        out_valid <= in_valid;
      end
      if (accept) begin
        out_imm     <= imm_d;
        out_fmt     <= fmt_d;
        out_illegal <= illegal_d;
        out_tag     <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: one XLEN=32 and one XLEN=64/RV64 instance share stimulus,
// each with its own expected queue of {tag, imm, fmt, illegal}.
module tb_imm_gen_pipe;

  localparam int TAG_W = 32;
  localparam int EW    = TAG_W + 64 + 3 + 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_inst = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_ready = 1'b0;

  logic             in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0]      out_imm_a;
  logic [2:0]       out_fmt_a;
  logic [TAG_W-1:0] out_tag_a;
  logic             in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0]      out_imm_b;
  logic [2:0]       out_fmt_b;
  logic [TAG_W-1:0] out_tag_b;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .ENABLE_RV64(0)) u32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a),
    .out_fmt(out_fmt_a), .out_illegal(out_illegal_a), .out_tag(out_tag_a)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .ENABLE_RV64(1)) u64 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
    .out_fmt(out_fmt_b), .out_illegal(out_illegal_b), .out_tag(out_tag_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [67:0] mk(input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    return {imm, fmt, ill};
  endfunction

  logic          held_prev = 1'b0;
  logic [EW-1:0] prev_a, prev_b;
  int            pop_cnt = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;

  always @(negedge clk) begin
    logic [EW-1:0] cur_a, cur_b;
    cur_a = {out_tag_a, 32'b0, out_imm_a, out_fmt_a, out_illegal_a};
    cur_b = {out_tag_b, out_imm_b, out_fmt_b, out_illegal_b};
    if (reset_n) begin
      if (out_valid_a !== out_valid_b) check("valid_agree", EW'(out_valid_b), EW'(out_valid_a));
      if (out_valid_a && !out_ready) check("stall_in_ready", EW'(in_ready_a), '0);
      if (held_prev) begin
        check("hold_stable32", cur_a, prev_a);
        check("hold_stable64", cur_b, prev_b);
      end
      if (out_valid_a && out_ready) begin
        if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
          check("unexpected_out", EW'(1), EW'(0));
        end else begin
          check("out32", cur_a, exp_a_q.pop_front());
          check("out64", cur_b, exp_b_q.pop_front());
        end
        if (pop_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        pop_cnt++;
      end
    end
    held_prev = reset_n && out_valid_a && !out_ready;
    prev_a = cur_a;
    prev_b = cur_b;
  end

  // driver: called at posedge+2, returns at posedge+2 after the accepting edge
  task automatic send(input logic [31:0] inst, input logic [TAG_W-1:0] tag,
                      input logic [67:0] e32, input logic [67:0] e64);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_tag   = tag;
    #1;
    while (!in_ready_a) begin
      @(posedge clk); #3;
      guard++;
      if (guard > 50) begin
        check("send_timeout", EW'(in_ready_a), EW'(1));
        break;
      end
    end
    if (in_ready_a !== in_ready_b) check("ready_agree", EW'(in_ready_b), EW'(in_ready_a));
    exp_a_q.push_back({tag, e32});
    exp_b_q.push_back({tag, e64});
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_valid32", EW'(out_valid_a), '0);
    check("rst_out64", {out_tag_b, out_imm_b, out_fmt_b, out_illegal_b}, '0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #2;

    send(32'hFFF00093, 32'h100, mk(64'hFFFFFFFF, 3'd1, 1'b0), mk(64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0));
    send(32'h4030D093, 32'h101, mk(64'h3, 3'd6, 1'b0), mk(64'h3, 3'd6, 1'b0));
    send(32'h02009093, 32'h102, mk(64'h0, 3'd0, 1'b1), mk(64'h20, 3'd6, 1'b0));
    send(32'hFE000EE3, 32'h103, mk(64'hFFFFFFFC, 3'd3, 1'b0), mk(64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0));
    send(32'h0080006F, 32'h104, mk(64'h8, 3'd5, 1'b0), mk(64'h8, 3'd5, 1'b0));
    send(32'hFE112E23, 32'h105, mk(64'hFFFFFFFC, 3'd2, 1'b0), mk(64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0));
    send(32'h800000B7, 32'h106, mk(64'h80000000, 3'd4, 1'b0), mk(64'hFFFFFFFF80000000, 3'd4, 1'b0));
    send(32'h03F09093, 32'h107, mk(64'h0, 3'd0, 1'b1), mk(64'h3F, 3'd6, 1'b0));
    send(32'h0200909B, 32'h108, mk(64'h0, 3'd0, 1'b1), mk(64'h0, 3'd0, 1'b1));
    send(32'h0050D09B, 32'h109, mk(64'h0, 3'd0, 1'b1), mk(64'h5, 3'd6, 1'b0));
    send(32'h0010809B, 32'h10A, mk(64'h0, 3'd0, 1'b1), mk(64'h1, 3'd1, 1'b0));
    send(32'h00B50533, 32'h10B, mk(64'h0, 3'd0, 1'b0), mk(64'h0, 3'd0, 1'b0));
    send(32'h00000000, 32'h10C, mk(64'h0, 3'd0, 1'b1), mk(64'h0, 3'd0, 1'b1));
    send(32'h12345097, 32'h10D, mk(64'h12345000, 3'd4, 1'b0), mk(64'h12345000, 3'd4, 1'b0));
    send(32'h8000A083, 32'h10E, mk(64'hFFFFF800, 3'd1, 1'b0), mk(64'hFFFFFFFFFFFFF800, 3'd1, 1'b0));
    send(32'h00F00073, 32'h10F, mk(64'hF, 3'd1, 1'b0), mk(64'hF, 3'd1, 1'b0));

    // backpressure: consumer stalls while three instructions stream in
    repeat (2) @(posedge clk); #2;
    out_ready = 1'b0;
    fork
      begin
        send(32'h00100093, 32'h200, mk(64'h1, 3'd1, 1'b0), mk(64'h1, 3'd1, 1'b0));
        send(32'h00200093, 32'h201, mk(64'h2, 3'd1, 1'b0), mk(64'h2, 3'd1, 1'b0));
        send(32'h00300093, 32'h202, mk(64'h3, 3'd1, 1'b0), mk(64'h3, 3'd1, 1'b0));
      end
      begin
        repeat (4) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #2;
    check("bp_drained", EW'(exp_a_q.size()), '0);

    // throughput: six back-to-back transfers with the consumer always ready
    pop_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      logic [63:0] v;
      v = 64'($urandom_range(0, 2047));
      send({v[11:0], 20'h00093}, TAG_W'(32'h300 + i), mk(v, 3'd1, 1'b0), mk(v, 3'd1, 1'b0));
    end
    repeat (3) @(posedge clk); #2;
    check("tput_count", EW'(pop_cnt), EW'(6));
    check("tput_span", EW'(last_cyc - first_cyc), EW'(5));

    // flush while a result is held and a new one is offered
    send(32'h00500093, 32'h400, mk(64'h5, 3'd1, 1'b0), mk(64'h5, 3'd1, 1'b0));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 32'h00600093;
    in_tag   = 32'h401;
    #1;
    check("flush_pre_valid", EW'(out_valid_a), EW'(1));
    check("flush_in_ready", EW'(in_ready_a), EW'(1));
    @(posedge clk); #2;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid32", EW'(out_valid_a), '0);
    check("flush_valid64", EW'(out_valid_b), '0);
    repeat (2) @(posedge clk); #2;
    check("flush_no_extra", EW'(out_valid_a), '0);

    // asynchronous reset while a result is stalled
    out_ready = 1'b0;
    send(32'hFFF00093, 32'h500, mk(64'hFFFFFFFF, 3'd1, 1'b0), mk(64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0));
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("arst_out32", {out_tag_a, out_imm_a, out_fmt_a, out_illegal_a, out_valid_a}, '0);
    check("arst_out64", {out_tag_b, out_imm_b, out_fmt_b, out_illegal_b}, '0);
    check("arst_valid64", EW'(out_valid_b), '0);
    exp_a_q.delete();
    exp_b_q.delete();
    held_prev = 1'b0;
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #2;
    send(32'h0080006F, 32'h600, mk(64'h8, 3'd5, 1'b0), mk(64'h8, 3'd5, 1'b0));

    repeat (4) @(posedge clk); #2;
    check("queue_empty32", EW'(exp_a_q.size()), '0);
    check("queue_empty64", EW'(exp_b_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
